grain_ctrl: RTL

//  Sequencer for the grain keystream datapath (80-bit LFSR + 24-bit NFSR, 105-bit Seed).
//  - Accepts a seed and a byte count from a requester.
//  - Drives the datapath's Par_load / shift_en through load and warm-up.
//  - Packs keystream bits into bytes behind a valid/ready handshake.
//  - Sits between the host/bus logic and the grain instance.

---
 rtl/grain_pkg.sv | 27 ++
 rtl/grain_ctrl_if.sv | 27 ++
 rtl/grain_byte_packer.sv | 59 +++++
 rtl/grain_ctrl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/grain_pkg.sv
// Shared constants, state encoding and bit-packing helper for the grain keystream sequencer.
package grain_pkg;
  localparam int GRAIN_LFSR_W = 80;
  localparam int GRAIN_NFSR_W = 24;
  localparam int GRAIN_SEED_W = GRAIN_LFSR_W + GRAIN_NFSR_W + 1;
  localparam int GRAIN_WARMUP = 160;
  localparam int GRAIN_LEN_W  = 16;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_WARM  = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    LOAD  = ST_LOAD,
    WARM  = ST_WARM,
    RUN   = ST_RUN,
    DRAIN = ST_DRAIN
  } state_e;

  // First keystream bit ends up in the MSB after eight pushes.
  function automatic logic [7:0] push_msb_first(input logic [7:0] coll, input logic b);
    return {coll[6:0], b};
  endfunction
endpackage

// File: rtl/grain_ctrl_if.sv
// Requester / keystream-consumer bundle between host logic and grain_ctrl.
interface grain_ctrl_if
  import grain_pkg::*;
#(
  parameter int SEED_W = GRAIN_SEED_W,
  parameter int LEN_W  = GRAIN_LEN_W
);
  logic              start;
  logic              abort;
  logic [SEED_W-1:0] seed_in;
  logic [LEN_W-1:0]  n_bytes;
  logic              busy;
  logic              done;
  logic [7:0]        ks_byte;
  logic              ks_valid;
  logic              ks_ready;

  modport master (
    output start, abort, seed_in, n_bytes, ks_ready,
    input  busy, done, ks_byte, ks_valid
  );

  modport slave (
    input  start, abort, seed_in, n_bytes, ks_ready,
    output busy, done, ks_byte, ks_valid
  );
endinterface

// File: rtl/grain_byte_packer.sv
// Collector plus output register: packs keystream bits MSB-first, presents bytes via valid/ready.
module grain_byte_packer
  import grain_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       take_bit,
  input  logic       bit_in,
  input  logic       ready,
  output logic       can_take,
  output logic [7:0] byte_out,
  output logic       valid
);
  logic [7:0] coll_r;
  logic [7:0] out_r;
  logic [3:0] cnt_r;
  logic       valid_r;
  logic       full_s;
  logic       out_free_s;
  logic       move_s;

  // A full collector may still take a bit when its byte leaves on the same edge.
  always_comb begin
    full_s     = (cnt_r == 4'd8);
    out_free_s = !valid_r || ready;
    move_s     = full_s && out_free_s;
    can_take   = !full_s || out_free_s;
  end

  // Collector and output register update.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      coll_r  <= 8'h00;
      out_r   <= 8'h00;
      cnt_r   <= 4'd0;
      valid_r <= 1'b0;
    end else begin
      if (move_s) begin
        out_r   <= coll_r;
        valid_r <= 1'b1;
      end else if (ready) begin
        valid_r <= 1'b0;
      end
      if (move_s && take_bit) begin
        coll_r <= push_msb_first(8'h00, bit_in);
        cnt_r  <= 4'd1;
      end else if (move_s) begin
        cnt_r  <= 4'd0;
      end else if (take_bit) begin
        coll_r <= push_msb_first(coll_r, bit_in);
        cnt_r  <= cnt_r + 4'd1;
      end
    end
  end

  assign byte_out = out_r;
  assign valid    = valid_r;
endmodule

// File: rtl/grain_ctrl.sv
// Sequencer for the grain keystream datapath: seed load, warm-up, and byte-packed keystream output.
module grain_ctrl
  import grain_pkg::*;
#(
  parameter int SEED_W = GRAIN_SEED_W,
  parameter int WARMUP = GRAIN_WARMUP,
  parameter int LEN_W  = GRAIN_LEN_W
)(
  input  logic              clk,
  input  logic              rst,
  grain_ctrl_if.slave       bus,
  output logic              Par_load,
  output logic              shift_en,
  output logic [SEED_W-1:0] Seed,
  input  logic              ks_bit
);
  localparam int WARM_CW = $clog2(WARMUP + 1);
  localparam int BIT_CW  = LEN_W + 3;

  state_e              state_r;
  logic                par_load_r;
  logic                busy_r;
  logic                done_r;
  logic [SEED_W-1:0]   seed_r;
  logic [LEN_W-1:0]    n_r;
  logic [WARM_CW-1:0]  warm_cnt_r;
  logic [BIT_CW-1:0]   bit_cnt_r;
  logic [LEN_W-1:0]    byte_cnt_r;

  logic                abort_s;
  logic                accept_s;
  logic                take_bit_s;
  logic                can_take_s;
  logic                last_bit_s;
  logic                last_byte_s;
  logic                shift_en_s;
  logic                ks_valid_s;
  logic [7:0]          ks_byte_s;

  // Shift only while the packer can absorb the bit, so no datapath step goes uncaptured.
  always_comb begin
    abort_s     = bus.abort && (state_r != IDLE);
    accept_s    = ks_valid_s && bus.ks_ready;
    if (state_r == WARM) begin
      shift_en_s = 1'b1;
    end else if (state_r == RUN) begin
      shift_en_s = can_take_s;
    end else begin
      shift_en_s = 1'b0;
    end
    take_bit_s  = (state_r == RUN) && shift_en_s;
    last_bit_s  = (bit_cnt_r == ({n_r, 3'b000} - BIT_CW'(1)));
    last_byte_s = (byte_cnt_r == (n_r - LEN_W'(1)));
  end

  // Job FSM, counters and registered control outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      par_load_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      seed_r     <= '0;
      n_r        <= '0;
      warm_cnt_r <= '0;
      bit_cnt_r  <= '0;
      byte_cnt_r <= '0;
    end else begin
      par_load_r <= 1'b0;
      done_r     <= 1'b0;
      if (abort_s) begin
        state_r    <= IDLE;
        busy_r     <= 1'b0;
        warm_cnt_r <= '0;
        bit_cnt_r  <= '0;
        byte_cnt_r <= '0;
      end else begin
        case (state_r)
          IDLE: begin
            if (bus.start && !bus.abort) begin
              if (bus.n_bytes != '0) begin
                seed_r     <= bus.seed_in;
                n_r        <= bus.n_bytes;
                state_r    <= LOAD;
                par_load_r <= 1'b1;
                busy_r     <= 1'b1;
                warm_cnt_r <= '0;
                bit_cnt_r  <= '0;
                byte_cnt_r <= '0;
              end else begin
                done_r <= 1'b1;
              end
            end
          end
          LOAD: begin
            state_r    <= WARM;
            warm_cnt_r <= '0;
          end
          WARM: begin
            if (warm_cnt_r == WARM_CW'(WARMUP - 1)) begin
              state_r <= RUN;
            end else begin
              warm_cnt_r <= warm_cnt_r + WARM_CW'(1);
            end
          end
          RUN: begin
            if (take_bit_s) begin
              bit_cnt_r <= bit_cnt_r + BIT_CW'(1);
              if (last_bit_s) begin
                state_r <= DRAIN;
              end
            end
            if (accept_s) begin
              byte_cnt_r <= byte_cnt_r + LEN_W'(1);
            end
          end
          DRAIN: begin
            if (accept_s) begin
              if (last_byte_s) begin
                state_r    <= IDLE;
                busy_r     <= 1'b0;
                done_r     <= 1'b1;
                byte_cnt_r <= '0;
              end else begin
                byte_cnt_r <= byte_cnt_r + LEN_W'(1);
              end
            end
          end
          default: begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  grain_byte_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .flush    (abort_s),
    .take_bit (take_bit_s),
    .bit_in   (ks_bit),
    .ready    (bus.ks_ready),
    .can_take (can_take_s),
    .byte_out (ks_byte_s),
    .valid    (ks_valid_s)
  );

  assign Par_load     = par_load_r;
  assign shift_en     = shift_en_s;
  assign Seed         = seed_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.ks_byte  = ks_byte_s;
  assign bus.ks_valid = ks_valid_s;
endmodule
